// File: rtl/fifo_rd_port_if.sv
// fifo_rd_port_if: memory, pointer and output-stream signals of the FIFO read port
interface fifo_rd_port_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 4
);
  logic [ADDRWIDTH:0] rq2_wptr;
  logic [ADDRWIDTH:0] rptr;
  logic [ADDRWIDTH-1:0] raddr;
  logic [DATAWIDTH-1:0] rmem_data;
  logic [DATAWIDTH-1:0] m_data;
  logic rempty;
  logic m_valid;
  logic m_ready;
  logic [1:0] rcount;
  modport master (
    input rq2_wptr, rmem_data, m_ready,
    output raddr, rptr, rempty, m_data, m_valid, rcount
  );
  modport slave (
    output rq2_wptr, rmem_data, m_ready,
    input raddr, rptr, rempty, m_data, m_valid, rcount
  );
endinterface

// File: rtl/fifo_rd_port.sv
// fifo_rd_port: read pointer, empty flag and 2-entry FWFT output buffer of the async FIFO
module fifo_rd_port #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 4
) (
  input logic rclk,
  input logic rrst,
  fifo_rd_port_if.master bus
);
  logic [ADDRWIDTH:0] rbin;
  logic [ADDRWIDTH:0] rbin_nxt;
  logic [DATAWIDTH-1:0] sdata;
  logic svalid;
  logic pop;
  logic fetch;
  assign bus.raddr = rbin[ADDRWIDTH-1:0];
  assign bus.rempty = bus.rptr == bus.rq2_wptr;
  assign bus.rcount = {1'b0, bus.m_valid} + {1'b0, svalid};
  assign pop = bus.m_valid & bus.m_ready;
  assign fetch = !bus.rempty & ((bus.rcount < 2'd2) | pop);
  assign rbin_nxt = rbin + 1'b1;
  // skid only ever holds a word while head is valid, so order is head then skid
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin <= '0;
      bus.rptr <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data <= '0;
      svalid <= 1'b0;
      sdata <= '0;
    end else begin
      if (fetch) begin
        rbin <= rbin_nxt;
        bus.rptr <= rbin_nxt ^ (rbin_nxt >> 1);
      end
      if (pop) begin
        bus.m_valid <= svalid | fetch;
        if (svalid) bus.m_data <= sdata;
        else if (fetch) bus.m_data <= bus.rmem_data;
        svalid <= svalid & fetch;
        if (svalid & fetch) sdata <= bus.rmem_data;
      end else if (fetch) begin
        if (bus.m_valid) begin
          sdata <= bus.rmem_data;
          svalid <= 1'b1;
        end else begin
          bus.m_data <= bus.rmem_data;
          bus.m_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_port.sv
// tb_fifo_rd_port: randomized read-port bench against a write-side memory and word-queue model
module tb_fifo_rd_port;
  logic rclk = 1'b0;
  logic rrst = 1'b1;
  logic [7:0] mem [16];
  logic [4:0] wbin = '0;
  logic [7:0] q [$];
  int vectors = 0;
  int miscompares = 0;
  int consumed = 0;
  int written = 0;
  bit saw_wrap = 0;
  fifo_rd_port_if #(.DATAWIDTH(8), .ADDRWIDTH(4)) bus ();
  fifo_rd_port #(.DATAWIDTH(8), .ADDRWIDTH(4)) dut (.rclk(rclk), .rrst(rrst), .bus(bus));
  always #5 rclk = ~rclk;
  assign bus.rq2_wptr = wbin ^ (wbin >> 1);
  assign bus.rmem_data = mem[bus.raddr];
  task automatic push_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    q.push_back(d);
    wbin = wbin + 1'b1;
    written++;
  endtask
  task automatic cycle();
    logic [4:0] p;
    logic [7:0] e;
    bit hold;
    #1;
    if (bus.m_valid && bus.m_ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: m_data=%h popped, model queue empty", bus.m_data);
      end else begin
        e = q.pop_front();
        consumed++;
        if (bus.m_data !== e) begin
          miscompares++;
          $display("FAIL pop_data: m_data=%h expected %h (word %0d)", bus.m_data, e, consumed - 1);
        end
      end
    end
    hold = bus.rcount == 2 && !bus.m_ready;
    p = bus.rptr;
    @(posedge rclk);
    #1;
    vectors++;
    if ($countones(p ^ bus.rptr) > 1) begin
      miscompares++;
      $display("FAIL rptr_gray_step: rptr %b -> %b", p, bus.rptr);
    end
    if (hold) begin
      vectors++;
      if (bus.rptr !== p) begin
        miscompares++;
        $display("FAIL fetch_when_full: rptr %b -> %b with rcount=2, m_ready=0", p, bus.rptr);
      end
    end
    if (p == 5'b10000 && bus.rptr == 5'b00000) saw_wrap = 1;
  endtask
  task automatic do_reset();
    rrst = 1'b1;
    bus.m_ready = 1'b0;
    wbin = '0;
    q.delete();
    consumed = 0;
    written = 0;
    repeat (3) @(posedge rclk);
    #1;
    rrst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.rempty !== 1'b1 || bus.m_valid !== 1'b0 || bus.rptr !== 5'd0 || bus.raddr !== 4'd0 || bus.rcount !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: rempty=%b m_valid=%b rptr=%b raddr=%h rcount=%0d, expected 1 0 00000 0 0",
               bus.rempty, bus.m_valid, bus.rptr, bus.raddr, bus.rcount);
    end
  endtask
  task automatic test_single();
    push_word(8'hA5);
    cycle();
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5 || bus.rptr !== 5'b00001 || bus.rempty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_fetch: m_valid=%b m_data=%h rptr=%b rempty=%b, expected 1 a5 00001 1",
               bus.m_valid, bus.m_data, bus.rptr, bus.rempty);
    end
    bus.m_ready = 1'b1;
    cycle();
    bus.m_ready = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.rcount !== 2'd0) begin
      miscompares++;
      $display("FAIL single_pop: m_valid=%b rcount=%0d, expected 0 0", bus.m_valid, bus.rcount);
    end
  endtask
  task automatic test_hold();
    do_reset();
    repeat (3) push_word(8'($urandom));
    repeat (3) cycle();
    vectors++;
    if (bus.rptr !== 5'b00011 || bus.rcount !== 2'd2 || bus.rempty !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== q[0]) begin
      miscompares++;
      $display("FAIL hold_full: rptr=%b rcount=%0d rempty=%b m_valid=%b m_data=%h, expected 00011 2 0 1 %h",
               bus.rptr, bus.rcount, bus.rempty, bus.m_valid, bus.m_data, q[0]);
    end
    bus.m_ready = 1'b1;
    repeat (4) cycle();
    bus.m_ready = 1'b0;
    vectors++;
    if (consumed != 3 || bus.rcount !== 2'd0 || bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_drain: consumed=%0d rcount=%0d m_valid=%b, expected 3 0 0", consumed, bus.rcount, bus.m_valid);
    end
  endtask
  task automatic test_back_to_back();
    int first;
    int run;
    int total;
    first = -1;
    run = 0;
    total = 0;
    do_reset();
    repeat (16) push_word(8'($urandom));
    bus.m_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (bus.m_valid) begin
        total++;
        if (first < 0) first = i;
        if (i - first == run) run++;
      end
    end
    bus.m_ready = 1'b0;
    vectors++;
    if (first != 0 || run != 16 || total != 16 || consumed != 16) begin
      miscompares++;
      $display("FAIL back_to_back: first=%0d run=%0d total=%0d consumed=%0d, expected 0 16 16 16", first, run, total, consumed);
    end
  endtask
  task automatic test_random_wrap();
    int budget;
    budget = 0;
    do_reset();
    saw_wrap = 0;
    while (consumed < 40 && budget < 3000) begin
      if (written < 40 && written - consumed < 16 && $urandom_range(3) != 0) push_word(8'($urandom));
      bus.m_ready = $urandom_range(1);
      cycle();
      budget++;
    end
    bus.m_ready = 1'b0;
    vectors++;
    if (consumed != 40 || q.size() != 0) begin
      miscompares++;
      $display("FAIL random_stream: consumed=%0d left=%0d, expected 40 0", consumed, q.size());
    end
    vectors++;
    if (!saw_wrap) begin
      miscompares++;
      $display("FAIL pointer_wrap: rptr never went gray(31)=10000 -> 00000");
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    repeat (5) push_word(8'($urandom));
    repeat (3) cycle();
    vectors++;
    if (bus.rcount !== 2'd2) begin
      miscompares++;
      $display("FAIL midreset_pre: rcount=%0d, expected 2", bus.rcount);
    end
    rrst = 1'b1;
    bus.m_ready = 1'b1;
    wbin = '0;
    q.delete();
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    bus.m_ready = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.rcount !== 2'd0 || bus.rptr !== 5'd0 || bus.raddr !== 4'd0 || bus.rempty !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_post: m_valid=%b rcount=%0d rptr=%b raddr=%h rempty=%b, expected 0 0 00000 0 1",
               bus.m_valid, bus.rcount, bus.rptr, bus.raddr, bus.rempty);
    end
  endtask
  initial begin
    bus.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_random_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
